frame_buffer_arbiter: RTL and testbench

FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

---
 rtl/frame_buffer_arbiter.sv | 110 +++++++++++
 tb/tb_frame_buffer_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: camera-write / LCD-read arbiter onto one Avalon-MM burst master.
// Define FBA_STATS_EN to add burst counters and peak camera grant latency outputs.
module frame_buffer_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 16,
  parameter int BURST_W      = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               c_req,
  input  logic [ADDR_W-1:0]  c_addr,
  input  logic [BURST_W-1:0] c_burstcount,
  input  logic [DATA_W-1:0]  c_wdata,
  input  logic               c_wvalid,
  output logic               c_grant,
  output logic               c_ack,
  input  logic               l_req,
  input  logic [ADDR_W-1:0]  l_addr,
  input  logic [BURST_W-1:0] l_burstcount,
  input  logic               l_urgent,
  output logic               l_grant,
  output logic [DATA_W-1:0]  l_rdata,
  output logic               l_rvalid,
  output logic [ADDR_W-1:0]  m_address,
  output logic               m_read,
  output logic               m_write,
  output logic [BURST_W-1:0] m_burstcount,
  output logic [DATA_W-1:0]  m_writedata,
  input  logic               m_waitrequest,
  input  logic [DATA_W-1:0]  m_readdata,
`ifdef FBA_STATS_EN
  output logic [31:0]        stat_c_bursts,
  output logic [31:0]        stat_l_bursts,
  output logic [15:0]        stat_max_wait,
`endif
  input  logic               m_readdatavalid
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD, RD_DATA} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [BURST_W-1:0] bc_q, beat_cnt, sel_bc;
  logic [SW-1:0] starve_cnt;
  logic last_l, any_req, pick_c, last_beat;
  always_comb begin
    any_req = c_req | l_req;
    // urgency first, then starvation boost, then round-robin against last owner
    pick_c = c_req & !(l_req & l_urgent) & ((starve_cnt >= LIMIT) | !l_req | last_l);
    sel_bc = pick_c ? c_burstcount : l_burstcount;
    last_beat = beat_cnt == bc_q - 1'b1;
    c_grant = state == WR_BURST;
    l_grant = (state == RD_CMD) | (state == RD_DATA);
    c_ack = c_grant & c_wvalid & !m_waitrequest;
    l_rvalid = (state == RD_DATA) & m_readdatavalid;
    l_rdata = state == RD_DATA ? m_readdata : '0;
    m_write = c_grant & c_wvalid;
    m_writedata = c_grant ? c_wdata : '0;
    m_read = state == RD_CMD;
    m_address = addr_q;
    m_burstcount = bc_q;
    state_nx = state;
    case (state)
      IDLE:     state_nx = any_req ? (pick_c ? WR_BURST : RD_CMD) : IDLE;
      WR_BURST: state_nx = (c_ack & last_beat) ? IDLE : WR_BURST;
      RD_CMD:   state_nx = m_waitrequest ? RD_CMD : RD_DATA;
      RD_DATA:  state_nx = (l_rvalid & last_beat) ? IDLE : RD_DATA;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      bc_q       <= '0;
      beat_cnt   <= '0;
      last_l     <= 1'b1;
      starve_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        addr_q   <= pick_c ? c_addr : l_addr;
        bc_q     <= sel_bc == '0 ? BURST_W'(1) : sel_bc;
        beat_cnt <= '0;
        last_l   <= !pick_c;
      end else if (c_ack | l_rvalid) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      starve_cnt <= (!c_req || c_grant) ? '0 : (starve_cnt == LIMIT ? starve_cnt : starve_cnt + 1'b1);
    end
  end
`ifdef FBA_STATS_EN
  logic [15:0] wait_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_c_bursts <= '0;
      stat_l_bursts <= '0;
      stat_max_wait <= '0;
      wait_cnt      <= '0;
    end else begin
      if (state == WR_BURST && state_nx == IDLE) stat_c_bursts <= stat_c_bursts + 1'b1;
      if (state == RD_DATA && state_nx == IDLE) stat_l_bursts <= stat_l_bursts + 1'b1;
      // wait_cnt holds the full latency on the first granted cycle
      if (c_grant && wait_cnt > stat_max_wait) stat_max_wait <= wait_cnt;
      wait_cnt <= (!c_req || c_grant) ? '0 : (&wait_cnt ? wait_cnt : wait_cnt + 1'b1);
    end
  end
`endif
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: directed vector table, corner sequences and randomized model check.
module tb_frame_buffer_arbiter;
  localparam int LIM = 64;
  logic clk = 0, reset = 1;
  logic c_req = 0, c_wvalid = 0, l_req = 0, l_urgent = 0, m_waitrequest = 0, m_readdatavalid = 0;
  logic [31:0] c_addr = 0, l_addr = 0, m_address;
  logic [7:0] c_burstcount = 0, l_burstcount = 0, m_burstcount;
  logic [15:0] c_wdata = 0, m_readdata = 0, l_rdata, m_writedata;
  logic c_grant, c_ack, l_grant, l_rvalid, m_read, m_write;
`ifdef FBA_STATS_EN
  logic [31:0] stat_c_bursts, stat_l_bursts;
  logic [15:0] stat_max_wait;
`endif
  frame_buffer_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_addr(c_addr), .c_burstcount(c_burstcount), .c_wdata(c_wdata),
    .c_wvalid(c_wvalid), .c_grant(c_grant), .c_ack(c_ack),
    .l_req(l_req), .l_addr(l_addr), .l_burstcount(l_burstcount), .l_urgent(l_urgent),
    .l_grant(l_grant), .l_rdata(l_rdata), .l_rvalid(l_rvalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_burstcount(m_burstcount),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
`ifdef FBA_STATS_EN
    .stat_c_bursts(stat_c_bursts), .stat_l_bursts(stat_l_bursts), .stat_max_wait(stat_max_wait),
`endif
    .m_readdatavalid(m_readdatavalid)
  );
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  // reference model: owner 0 none, 1 camera, 2 LCD
  int own, left, starve, waitc, maxw, nc, nl;
  bit cmd_ok, last_c;
  logic [31:0] e_addr, c_addr_v, l_addr_v;
  logic [7:0] e_bc;

  typedef struct packed {
    logic rs, cr, lr, lu, wv, wr, rv;
    logic [7:0] bc;
    logic [5:0] exp;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [5:0] ctl();
    return {c_grant, l_grant, m_write, m_read, c_ack, l_rvalid};
  endfunction

  task automatic model_reset();
    own = 0; left = 0; cmd_ok = 0; last_c = 0;
    starve = 0; waitc = 0; maxw = 0; nc = 0; nl = 0;
  endtask

  task automatic model_step();
    logic [5:0] e;
    bit g;
    int w;
    e = {own == 1, own == 2, own == 1 && c_wvalid, own == 2 && !cmd_ok,
         own == 1 && c_wvalid && !m_waitrequest, own == 2 && cmd_ok && m_readdatavalid};
    chk("ctl", 128'(ctl()), 128'(e));
    if (own != 0) chk("addr_bc", 128'({m_address, m_burstcount}), 128'({e_addr, e_bc}));
    if (own == 1) chk("wdata", 128'(m_writedata), 128'(c_wdata));
    if (e[0]) chk("rdata", 128'(l_rdata), 128'(m_readdata));
    g = own == 1;
    if (g && waitc > maxw) maxw = waitc;
    if (own == 0) begin
      if (c_req || l_req) begin
        if (l_req && l_urgent) w = 2;
        else if (c_req && starve >= LIM) w = 1;
        else if (c_req && l_req) w = last_c ? 2 : 1;
        else w = c_req ? 1 : 2;
        own = w;
        last_c = w == 1;
        e_addr = w == 1 ? c_addr : l_addr;
        e_bc = w == 1 ? c_burstcount : l_burstcount;
        if (e_bc == 0) e_bc = 1;
        left = int'(e_bc);
        cmd_ok = 0;
      end
    end else if (own == 1) begin
      if (c_wvalid && !m_waitrequest) begin
        left--;
        if (left == 0) begin own = 0; nc++; end
      end
    end else if (!cmd_ok) begin
      cmd_ok = !m_waitrequest;
    end else if (m_readdatavalid) begin
      left--;
      if (left == 0) begin own = 0; nl++; end
    end
    starve = (c_req && !g) ? (starve < LIM ? starve + 1 : LIM) : 0;
    waitc = (c_req && !g) ? waitc + 1 : 0;
  endtask

  task automatic step(input logic cr, lr, lu, wv, wr, rv, input logic [7:0] cbc, lbc);
    @(negedge clk);
    c_req = cr; l_req = lr; l_urgent = lu; c_wvalid = wv;
    m_waitrequest = wr; m_readdatavalid = rv;
    c_burstcount = cbc; l_burstcount = lbc;
    c_addr = c_addr_v; l_addr = l_addr_v;
    c_wdata = 16'($urandom); m_readdata = 16'($urandom);
    #1 model_step();
  endtask

  // asserted between edges so the async clear is observed before any clock
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    #1 chk("reset_outs", 128'({c_grant, c_ack, l_grant, l_rvalid, m_read, m_write,
                               m_address, m_burstcount, m_writedata, l_rdata}), 128'(0));
`ifdef FBA_STATS_EN
    chk("reset_stats", 128'({stat_c_bursts, stat_l_bursts, stat_max_wait}), 128'(0));
`endif
    model_reset();
    @(negedge clk);
    c_req = 0; l_req = 0; l_urgent = 0; c_wvalid = 0; m_waitrequest = 0; m_readdatavalid = 0;
    reset = 0;
  endtask

  task automatic add(input logic [6:0] in, input logic [7:0] bc, input logic [5:0] exp, input int n = 1);
    for (int i = 0; i < n; i++) tv.push_back(vec_t'({in, bc, exp}));
  endtask

  initial begin
    model_reset();
    c_addr_v = 32'h1000; l_addr_v = 32'h2000;
    // fields: rs cr lr lu wv wr rv ; exp: c_grant l_grant m_write m_read c_ack l_rvalid
    add(7'b1100100, 4, 6'b000000);
    add(7'b0100100, 4, 6'b101010, 4);
    add(7'b0000000, 4, 6'b000000);
    add(7'b0010000, 8, 6'b000000);
    add(7'b0010010, 8, 6'b010100);
    add(7'b0000010, 8, 6'b010100, 2);
    add(7'b0000000, 8, 6'b010100);
    add(7'b0000000, 8, 6'b010000);
    add(7'b0000001, 8, 6'b010001, 8);
    add(7'b0000001, 8, 6'b000000);
    add(7'b1110101, 2, 6'b000000);
    add(7'b0110101, 2, 6'b101010, 2);
    add(7'b0110101, 2, 6'b000000);
    add(7'b0110101, 2, 6'b010100);
    add(7'b0110101, 2, 6'b010001, 2);
    add(7'b0110101, 2, 6'b000000);
    add(7'b0110101, 2, 6'b101010, 2);
    add(7'b0110101, 2, 6'b000000);
    add(7'b0110101, 2, 6'b010100);
    add(7'b0110101, 2, 6'b010001, 2);
    add(7'b0111101, 2, 6'b000000);
    add(7'b0000001, 2, 6'b010100);
    add(7'b0000001, 2, 6'b010001, 2);
    add(7'b0000001, 2, 6'b000000);
    add(7'b1100100, 0, 6'b000000);
    add(7'b0000100, 0, 6'b101010);
    add(7'b0000000, 0, 6'b000000);
    add(7'b0010000, 0, 6'b000000);
    add(7'b0000000, 0, 6'b010100);
    add(7'b0000001, 0, 6'b010001);
    add(7'b0000001, 0, 6'b000000);
    foreach (tv[i]) begin
      if (tv[i].rs) do_reset();
      step(tv[i].cr, tv[i].lr, tv[i].lu, tv[i].wv, tv[i].wr, tv[i].rv, tv[i].bc, tv[i].bc);
      chk($sformatf("vec%0d", i), 128'(ctl()), 128'(tv[i].exp));
    end

    // reset at beat 3 of an 8-beat read, then stray beats must be dropped
    do_reset();
    step(0, 1, 0, 0, 0, 0, 8, 8);
    step(0, 0, 0, 0, 0, 0, 8, 8);
    repeat (3) step(0, 0, 0, 1, 0, 1, 8, 8);
    do_reset();
    repeat (5) begin
      step(0, 0, 0, 1, 0, 1, 8, 8);
      chk("post_reset_rvalid", 128'(l_rvalid), 128'(0));
    end

    // camera starves behind a stalled urgent read; urgency still wins, then camera
    do_reset();
    step(1, 1, 1, 1, 1, 0, 2, 2);
    step(1, 0, 0, 1, 1, 0, 2, 2);
    chk("urgent_first", 128'({c_grant, l_grant}), 128'(2'b01));
    repeat (70) step(1, 0, 0, 1, 1, 0, 2, 2);
    step(1, 0, 0, 1, 0, 0, 2, 2);
    repeat (2) step(1, 0, 0, 1, 0, 1, 2, 2);
    step(1, 1, 1, 1, 0, 0, 2, 2);
    step(1, 0, 0, 1, 0, 0, 2, 2);
    chk("urgent_over_boost", 128'({c_grant, l_grant}), 128'(2'b01));
    repeat (2) step(1, 0, 0, 1, 0, 1, 2, 2);
    step(1, 1, 0, 1, 0, 0, 2, 2);
    step(0, 0, 0, 1, 0, 0, 2, 2);
    chk("starved_c", 128'({c_grant, l_grant}), 128'(2'b10));
    step(0, 0, 0, 1, 0, 0, 2, 2);

    // randomized traffic against the model
    do_reset();
    repeat (3000) begin
      c_addr_v = $urandom; l_addr_v = $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)));
    end
    for (int n = 0; n < 600 && own != 0; n++) step(0, 0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("drain_idle", 128'(ctl()), 128'(0));
`ifdef FBA_STATS_EN
    chk("stat_c_bursts", 128'(stat_c_bursts), 128'(nc));
    chk("stat_l_bursts", 128'(stat_l_bursts), 128'(nl));
    chk("stat_max_wait", 128'(stat_max_wait), 128'(maxw));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
